// File: rtl/input_pkg.sv
// Shared types and default timing constants for the front-panel input blocks.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  localparam int DEB_STABLE_CYCLES_DEFAULT = 100000;
  localparam int DEB_REPEAT_PERIOD_DEFAULT = 5000000;

  function automatic int deb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, symmetric stability filter and auto-repeat FSM.
//
//   state  | meaning
//   IDLE   | button released (or auto-repeat disabled)
//   HOLD   | press accepted, waiting out the initial repeat delay
//   REPEAT | emitting repeat pulses every REPEAT_PERIOD cycles
module debounce_channel
  import input_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEFAULT,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int RW = $clog2(deb_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic          PIN_IDLE = (ACTIVE_LOW != 0);
  localparam logic          REP_EN   = (REPEAT_DELAY != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST  = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic [1:0]    sync_q;
  logic          raw;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  repeat_state_t state_q, state_d;

  // Synchroniser idles at the inactive pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{PIN_IDLE}};
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign raw = sync_q[1] ^ PIN_IDLE;

  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (raw == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d   = raw;
      cnt_d     = '0;
      press_d   = raw;
      release_d = ~raw;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Release wins over a coincident repeat match so no pulse follows the release.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (REP_EN && press_d) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end
      end
      HOLD: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RD_LAST) begin
          state_d  = REPEAT;
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      REPEAT: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RP_LAST) begin
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      rcnt_q    <= '0;
      state_q   <= IDLE;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  assign btn_o     = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent button debouncers with press/release pulses and auto-repeat.
module button_debounce_bank
  import input_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEFAULT,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] btn_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_i[g]),
      .btn_o    (btn_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Randomised bench for button_debounce_bank: an active-high and an active-low instance
// are driven with complementary pins and both compared against a sliding-window model.
module tb_button_debounce_bank;

  localparam int N = 2;
  localparam int S = 8;
  localparam int D = 20;
  localparam int P = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_log = '0;
  logic [N-1:0] btn_al;
  logic [N-1:0] d0_btn, d0_prs, d0_rel, d0_rep;
  logic [N-1:0] d1_btn, d1_prs, d1_rel, d1_rep;

  int n_checks = 0;
  int n_errors = 0;

  assign btn_al = ~btn_log;

  always #5 clk = ~clk;

  button_debounce_bank #(
    .N_CH(N), .STABLE_CYCLES(S), .ACTIVE_LOW(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn_log),
    .btn_o(d0_btn), .press_o(d0_prs), .release_o(d0_rel), .repeat_o(d0_rep)
  );

  button_debounce_bank #(
    .N_CH(N), .STABLE_CYCLES(S), .ACTIVE_LOW(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_i(btn_al),
    .btn_o(d1_btn), .press_o(d1_prs), .release_o(d1_rel), .repeat_o(d1_rep)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, want);
    end
  endtask

  // Reference model in the logical (pressed = 1) domain. A new level is accepted once
  // the last S synchronised samples all differ from the current level; repeats are
  // plain arithmetic on the number of cycles since the accepted press.
  bit           m_s1 [N];
  bit           m_s2 [N];
  bit           m_lvl[N];
  bit [S-1:0]   m_win[N];
  int           m_fill[N];
  bit           m_held[N];
  int           m_age[N];
  bit [N-1:0]   e_btn, e_prs, e_rel, e_rep;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < N; ch++) begin
        m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0;
        m_win[ch] = '0; m_fill[ch] = 0; m_held[ch] = 1'b0; m_age[ch] = 0;
      end
      e_btn = '0; e_prs = '0; e_rel = '0; e_rep = '0;
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        bit raw;
        bit accept;
        raw = m_s2[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = btn_log[ch];
        m_win[ch] = {m_win[ch][S-2:0], raw};
        if (m_fill[ch] < S) m_fill[ch]++;
        accept = (m_fill[ch] == S) && (m_win[ch] == {S{~m_lvl[ch]}});
        e_prs[ch] = 1'b0; e_rel[ch] = 1'b0; e_rep[ch] = 1'b0;
        if (accept) begin
          m_lvl[ch] = raw;
          e_prs[ch] = raw;
          e_rel[ch] = ~raw;
          m_held[ch] = raw;
          m_age[ch] = 0;
        end else if (m_held[ch]) begin
          m_age[ch]++;
          if (m_age[ch] == D || (m_age[ch] > D && (m_age[ch] - D) % P == 0))
            e_rep[ch] = 1'b1;
        end
        e_btn[ch] = m_lvl[ch];
      end
    end
  end

  always @(negedge clk) begin
    check("btn_o",       32'(d0_btn), 32'(e_btn));
    check("press_o",     32'(d0_prs), 32'(e_prs));
    check("release_o",   32'(d0_rel), 32'(e_rel));
    check("repeat_o",    32'(d0_rep), 32'(e_rep));
    check("al_btn_o",    32'(d1_btn), 32'(e_btn));
    check("al_press_o",  32'(d1_prs), 32'(e_prs));
    check("al_release_o",32'(d1_rel), 32'(e_rel));
    check("al_repeat_o", 32'(d1_rep), 32'(e_rep));
  end

  // Inputs change 1 time unit after the falling edge, well clear of both edges.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int rep_cnt;
    int rep_first;
    int glitches;

    // Reset with both buttons held: outputs zero at once, press lands on edge 10.
    btn_log = 2'b11;
    #1 rst = 1'b1;
    #1;
    check("rst_async_out", 32'({d0_btn, d0_prs, d0_rel, d0_rep}), 32'(0));
    check("rst_async_al",  32'({d1_btn, d1_prs, d1_rel, d1_rep}), 32'(0));
    step(3);
    rst = 1'b0;
    step(9);
    check("held_rst_early", 32'(d0_prs), 32'(0));
    step(1);
    check("held_rst_press",    32'(d0_prs), 32'(2'b11));
    check("held_rst_btn",      32'(d0_btn), 32'(2'b11));
    check("held_rst_press_al", 32'(d1_prs), 32'(2'b11));

    btn_log = 2'b00;
    step(40);

    // Single press on channel 0, then auto-repeat while held.
    btn_log[0] = 1'b1;
    step(9);
    check("ch0_press_early", 32'(d0_prs[0]), 32'(0));
    step(1);
    check("ch0_press",       32'(d0_prs), 32'(2'b01));
    check("ch0_btn",         32'(d0_btn), 32'(2'b01));
    check("ch0_press_al",    32'(d1_prs), 32'(2'b01));
    rep_cnt = 0;
    rep_first = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (d0_rep[0]) begin
        rep_cnt++;
        if (rep_first == 0) rep_first = k;
      end
      if (k == 1) check("ch0_press_one_cycle", 32'(d0_prs[0]), 32'(0));
    end
    check("rep_count", 32'(rep_cnt), 32'(5));
    check("rep_first", 32'(rep_first), 32'(D));
    btn_log[0] = 1'b0;
    step(9);
    check("ch0_rel_early", 32'(d0_rel[0]), 32'(0));
    step(1);
    check("ch0_release",    32'(d0_rel), 32'(2'b01));
    check("ch0_rel_no_rep", 32'(d0_rep), 32'(0));
    check("ch0_release_al", 32'(d1_rel), 32'(2'b01));
    rep_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (d0_rep[0] || d1_rep[0]) rep_cnt++;
    end
    check("rep_after_release", 32'(rep_cnt), 32'(0));

    // Bounce: 7 high / 1 low never survives the filter.
    glitches = 0;
    for (int i = 0; i < 100; i++) begin
      btn_log[0] = (i % 8 != 7);
      step(1);
      if (d0_btn[0] || d0_prs[0] || d0_rel[0]) glitches++;
      if (d1_btn[0] || d1_prs[0] || d1_rel[0]) glitches++;
    end
    check("bounce_glitches", 32'(glitches), 32'(0));
    btn_log[0] = 1'b0;
    step(15);

    // Both channels pressed together.
    btn_log = 2'b11;
    step(10);
    check("both_press",    32'(d0_prs), 32'(2'b11));
    check("both_press_al", 32'(d1_prs), 32'(2'b11));
    btn_log = 2'b00;
    step(15);
    check("both_released", 32'(d0_btn), 32'(0));

    // Reset after count 5 discards progress; press accepted 10 edges after release of reset.
    btn_log[0] = 1'b1;
    step(7);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(9);
    check("rst_mid_early", 32'(d0_prs[0]), 32'(0));
    step(1);
    check("rst_mid_press",    32'(d0_prs[0]), 32'(1));
    check("rst_mid_press_al", 32'(d1_prs[0]), 32'(1));
    btn_log = 2'b00;
    step(15);

    // Random pins: a fast-toggling phase then a slow one with longer holds.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int span;
      span = (cyc < 1500) ? 6 : 40;
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, span) == 0) btn_log[ch] = ~btn_log[ch];
      rst = ($urandom_range(0, 799) == 0);
      step(1);
    end
    rst = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_bank.md
# button_debounce_bank

Parametrised multi-channel debouncer for the front-panel and joystick buttons. Each of `N_CH` raw asynchronous inputs is synchronised and filtered symmetrically on press and release. The block delivers a clean level, one-cycle press and release pulses, and an optional auto-repeat pulse train while a button is held. It sits between the board pins and the game-control logic and replaces the single-channel, press-only debouncer.

## Interface
- `N_CH`, 4: number of independent channels (≥1).
- `STABLE_CYCLES`, 100000: consecutive cycles a new input value must hold before it is accepted (≥2).
- `ACTIVE_LOW`, 0: 1 = pins are active-low and are inverted after synchronisation.
- `REPEAT_DELAY`, 0: cycles from press acceptance to the first `repeat_o` pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent `repeat_o` pulses (≥1).
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_i` in N_CH: raw asynchronous button pins.
- `btn_o` out N_CH: debounced level, 1 = pressed.
- `press_o` out N_CH: one-cycle pulse on accepted press.
- `release_o` out N_CH: one-cycle pulse on accepted release.
- `repeat_o` out N_CH: one-cycle auto-repeat pulses while held.

## Operation
- Per channel: 2-FF synchroniser → optional inversion → `raw`. The synchroniser FFs reset to the inactive pin level (1 if `ACTIVE_LOW`, else 0).
- Filter state `level` and counter `cnt`, width `$clog2(STABLE_CYCLES)`:
  - If `raw == level`, `cnt <= 0`. Any single matching cycle restarts the count.
  - If `raw != level` and `cnt == STABLE_CYCLES-1`: `level <= raw`, `cnt <= 0`, and assert `press_o` (new level 1) or `release_o` (new level 0) for exactly one cycle.
  - Otherwise `cnt <= cnt + 1`.
- The filter is symmetric: press and release need the same stability.
- Repeat FSM per channel, with states IDLE, HOLD, REPEAT and counter `rcnt`:
  - IDLE → HOLD on accepted press, `rcnt <= 0`.
  - HOLD: `rcnt` increments each cycle. When `rcnt == REPEAT_DELAY-1`, pulse `repeat_o`, `rcnt <= 0`, go to REPEAT.
  - REPEAT: `rcnt` increments each cycle. When `rcnt == REPEAT_PERIOD-1`, pulse `repeat_o`, `rcnt <= 0`.
  - HOLD or REPEAT → IDLE on accepted release, same cycle as `release_o`. No `repeat_o` in that cycle.
  - If `REPEAT_DELAY == 0`, the FSM stays in IDLE and `repeat_o` is tied to 0.
- `rcnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`. It never wraps, because it is cleared on match.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- `press_o` and `repeat_o` never assert in the same cycle on one channel: the first repeat comes at least 1 cycle after the press.

## Timing
- Reset (async assert, sync use after deassert): `btn_o`, `press_o`, `release_o`, `repeat_o` = 0; `level` = 0; all counters = 0; FSM = IDLE. The outputs are 0 combinationally on assertion.
- All outputs are registered.
- Latency: number the edge that first samples the changed pin as edge 1. `btn_o` and the press/release pulse change after edge `STABLE_CYCLES+2`, provided the pin is stable throughout.
- `repeat_o` first pulse: `REPEAT_DELAY` cycles after the `press_o` cycle. Subsequent pulses every `REPEAT_PERIOD` cycles.
- Reset mid-count discards all progress. A button held through reset deassertion is accepted as a press `STABLE_CYCLES+2` edges after deassertion.

## Structure
- Shared package `input_pkg`:
  - `repeat_state_t` enum (IDLE, HOLD, REPEAT).
  - Default constants `DEB_STABLE_CYCLES_DEFAULT` and `DEB_REPEAT_PERIOD_DEFAULT`.
- Sub-module `debounce_channel`: one synchroniser, filter and repeat FSM. The top level instantiates it `N_CH` times with a generate loop.

## Test plan
Bench parameters: `N_CH=2`, `STABLE_CYCLES=8`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=5`, `ACTIVE_LOW=0`.
- Assert `rst` with `btn_i=2'b11` → all outputs 0 immediately and during reset. Deassert and hold → `btn_o=2'b11` and `press_o=2'b11` together after edge 10.
- `btn_i[0]` 0→1 sampled at edge 1 and held → `btn_o[0]=1` and a one-cycle `press_o[0]` after edge 10. Channel 1 is unaffected.
- Bounce: `btn_i[0]` alternates 7 cycles high, 1 cycle low, for 100 cycles → `btn_o[0]` stays 0 and no pulses occur.
- Hold channel 0 for 40 cycles after the press pulse → `repeat_o[0]` pulses at +20, +25, +30, +35, +40. Release → `release_o[0]` 10 edges after the pin falls, with no further `repeat_o`.
- Both channels pressed in the same cycle → `press_o=2'b11` in a single cycle.
- `rst` pulse at count 5 of a press → counter cleared; the press is accepted 10 edges after deassertion.
- Repeat the press test with `ACTIVE_LOW=1` and pins idle high → same results with inverted stimulus.
